st7789_spi_rx: RTL and testbench
================================

# st7789_spi_rx

Receive-side model of the ST7789 4-wire SPI link (CSN, SCK, MOSI, DC). Oversamples the serial pins in the local clock domain, assembles bytes, and decodes CASET, RASET and RAMWR into addressed RGB565 pixel writes. It sits opposite the display scan core and serves as a display emulator feeding a framebuffer, or as a bus monitor in benches.

## Interface
Parameters:
- C_x_size, 240, horizontal pixel count; C_x_bits = $clog2(C_x_size)
- C_y_size, 240, vertical pixel count; C_y_bits = $clog2(C_y_size)

Ports:
- clk  in  1  oversampling clock; single clock domain
- reset  in  1  asynchronous, active-high
- oled_csn, oled_clk, oled_mosi, oled_dc  in  1 each  asynchronous SPI pins
- pixel_valid  out  1  one-cycle strobe per in-range pixel
- pixel_x  out  C_x_bits  pixel column
- pixel_y  out  C_y_bits  pixel row
- pixel_color  out  16  RGB565, high byte first on wire
- cmd_valid  out  1  one-cycle strobe per command byte (see Configuration)
- cmd_code  out  8  last command byte

## Operation
- Pins pass through 2-FF synchronizers. SCK rising edge detected from the synchronized value; MOSI and DC sampled on that edge, MSB first.
- Bit counter 0..7. On the 8th edge: byte_valid and byte_is_data (DC at bit 0) are latched and the counter clears.
- CSN high clears the bit counter and the pixel high/low phase and drops any partial byte. Command state persists across CSN pulses.
- FSM states, reset state IDLE:
  - DC=0 byte from any state: command. 0x2A or 0x2B goes to ARGS with arg index 0. 0x2C goes to RAMWR with x<=xs, y<=ys, phase<=high. Any other command goes to SKIP.
  - ARGS: data bytes fill start_hi, start_lo, end_hi, end_lo of the column or row window, 16-bit each. After the 4th byte the FSM returns to IDLE. Extra data bytes in IDLE are ignored.
  - RAMWR: data bytes alternate high/low. On the low byte, pixel_color is {hi, lo} and the address advances:
    - if x >= xe: x <= xs and y advances; otherwise x <= x+1.
    - y advances the same way: if y >= ye then y <= ys, otherwise y <= y+1.
    - xs > xe therefore gives a single column at xs.
  - SKIP: data bytes discarded.
- pixel_valid is asserted only when the address is in range (x < C_x_size and y < C_y_size). The address still advances when the pixel is suppressed.
- Reset values:
  - window xs=0, xe=C_x_size-1, ys=0, ye=C_y_size-1
  - x, y = 0; FSM in IDLE
  - all outputs 0
- Reset mid-byte or mid-RAMWR discards everything in progress.

## Timing
- SCK high and low phases must each last at least 2 clk periods. clk must run ≥ 4× SCK, i.e. ≥ 2× the clock of the scan core.
- Latency: byte_valid is 3 clk after the SCK rising edge reaches the synchronizer input. pixel_valid, pixel_x/y and pixel_color are registered 1 clk after the low byte's byte_valid. Total: 4 clk.
- pixel_x, pixel_y and pixel_color hold between strobes.
- A byte and the CSN rising edge completing in the same cycle: the byte is accepted, then the counter clears.

## Configuration
- ST7789_RX_CMD_MON_EN defined: cmd_valid pulses 1 clk with cmd_code updated for every DC=0 byte, including ignored commands.
- Undefined: cmd_valid and cmd_code are tied to 0, and the related logic is removed. Pixel path is identical in both builds.

## Structure
- Package st7789_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - FSM state enum {IDLE, ARGS, RAMWR, SKIP}
  - default window limits
- Sub-module st7789_spi_deser holds the synchronizers, SCK edge detect and bit counter. Its outputs are byte_valid, byte, byte_is_data and csn_high.

## Test plan
- CASET 00 0A 00 0C, RASET 00 05 00 06, RAMWR, then pixels F800 07E0 001F -> pixels (10,5)=F800, (11,5)=07E0, (12,5)=001F.
- Continuing the same RAMWR with 4 more pixels -> (10,6), (11,6), (12,6), then wrap to (10,5).
- Command 0x36 with data 0x60, then 2 data bytes -> no pixel_valid and window unchanged. With the macro defined, cmd_valid fires once with cmd_code=0x36.
- CSN pulsed high after 5 bits of a byte, then a full 0x2C -> partial byte dropped and RAMWR entered. The first pixel lands at (xs, ys).
- CASET 00 EF 00 F0 (239..240), RAMWR, 3 pixels -> (239,y) reported, x=240 suppressed, third pixel at (239,y+1).
- reset asserted between the high and low byte of a pixel -> outputs 0 immediately and window restored to defaults. After reset, a RAMWR plus 1 pixel reports (0,0).

Source files
------------

// File: rtl/st7789_pkg.sv
// st7789_pkg
// Shared definitions for the ST7789 SPI receive model: the three decoded
// command codes, the receiver state encoding and the default panel size
// that also seeds the reset-time column/row window.
package st7789_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEFAULT_X_SIZE = 240;
    localparam int DEFAULT_Y_SIZE = 240;

    typedef enum logic [1:0] {
        IDLE,
        ARGS,
        RAMWR,
        SKIP
    } rxState_t;

endpackage

// File: rtl/st7789_spi_deser.sv
// st7789_spi_deser
// Brings the four asynchronous SPI pins into the clk domain, finds SCK
// rising edges and shifts MOSI in MSB first, producing one strobe per
// completed byte.
// Ports:
//   clk, reset                       oversampling clock, async active-high reset
//   oled_csn/clk/mosi/dc             raw SPI pins
//   byte_valid_o                     one-cycle strobe per completed byte
//   byte_o                           the completed byte
//   byte_is_data_o                   DC level sampled with the last bit
//   csn_high_o                       synchronized chip-select (deselected)
module st7789_spi_deser
    import st7789_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       oled_csn,
    input  logic       oled_clk,
    input  logic       oled_mosi,
    input  logic       oled_dc,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       byte_is_data_o,
    output logic       csn_high_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic       sckPrev_q;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byteValid_q, byteValid_d;
    logic [7:0] byte_q, byte_d;
    logic       isData_q, isData_d;
    logic       sckRise;

    // Two-flop synchronizers for {csn, sck, mosi, dc}. Chip select resets to
    // the deselected level so nothing is assembled before the pins settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q    <= 4'b1000;
            sync_q    <= 4'b1000;
            sckPrev_q <= 1'b0;
        end else begin
            meta_q    <= {oled_csn, oled_clk, oled_mosi, oled_dc};
            sync_q    <= meta_q;
            sckPrev_q <= sync_q[2];
        end
    end

    assign sckRise    = sync_q[2] & ~sckPrev_q;
    assign csn_high_o = sync_q[3];

    // Shift on each SCK rise; the eighth rise emits the byte together with
    // DC. A deselected chip forces the counter to zero after any byte that
    // finished in the same cycle has already been emitted.
    always_comb begin
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        byteValid_d = 1'b0;
        byte_d      = byte_q;
        isData_d    = isData_q;
        if (sckRise) begin
            shift_d = {shift_q[5:0], sync_q[1]};
            if (bitCnt_q == 3'd7) begin
                byteValid_d = 1'b1;
                byte_d      = {shift_q, sync_q[1]};
                isData_d    = sync_q[0];
                bitCnt_d    = 3'd0;
            end else begin
                bitCnt_d = bitCnt_q + 3'd1;
            end
        end
        if (sync_q[3]) begin
            bitCnt_d = 3'd0;
        end
    end

    // Byte assembly state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt_q    <= 3'd0;
            shift_q     <= 7'd0;
            byteValid_q <= 1'b0;
            byte_q      <= 8'd0;
            isData_q    <= 1'b0;
        end else begin
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            byteValid_q <= byteValid_d;
            byte_q      <= byte_d;
            isData_q    <= isData_d;
        end
    end

    assign byte_valid_o   = byteValid_q;
    assign byte_o         = byte_q;
    assign byte_is_data_o = isData_q;

endmodule

// File: rtl/st7789_spi_rx.sv
// st7789_spi_rx
// Receive-side model of the ST7789 4-wire SPI link. Decodes CASET/RASET
// into a column/row window and turns RAMWR data into addressed RGB565 pixel
// strobes that walk the window row by row.
// Ports:
//   clk, reset                     oversampling clock, async active-high reset
//   oled_csn/clk/mosi/dc           raw SPI pins
//   pixel_valid                    one-cycle strobe per in-range pixel
//   pixel_x, pixel_y, pixel_color  address and RGB565 value of the last pixel
//   cmd_valid, cmd_code            command monitor strobe and last command
// Build option: define ST7789_RX_CMD_MON_EN to enable the command monitor;
// otherwise cmd_valid and cmd_code are held at zero.
module st7789_spi_rx
    import st7789_pkg::*;
#(
    parameter int C_x_size = DEFAULT_X_SIZE,
    parameter int C_y_size = DEFAULT_Y_SIZE,
    localparam int C_x_bits = $clog2(C_x_size),
    localparam int C_y_bits = $clog2(C_y_size)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                oled_csn,
    input  logic                oled_clk,
    input  logic                oled_mosi,
    input  logic                oled_dc,
    output logic                pixel_valid,
    output logic [C_x_bits-1:0] pixel_x,
    output logic [C_y_bits-1:0] pixel_y,
    output logic [15:0]         pixel_color,
    output logic                cmd_valid,
    output logic [7:0]          cmd_code
);

    localparam logic [15:0] X_SIZE16 = 16'(C_x_size);
    localparam logic [15:0] Y_SIZE16 = 16'(C_y_size);

    logic       byteValid, byteIsData, csnHigh;
    logic [7:0] rxByte;

    rxState_t      state_q, state_d;
    logic [1:0]    argIdx_q, argIdx_d;
    logic          winRow_q, winRow_d;
    logic [15:0]   xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0]   x_q, x_d, y_q, y_d;
    logic          phaseLow_q, phaseLow_d;
    logic [7:0]    hi_q, hi_d;
    logic          pixelValid_q, pixelValid_d;
    logic [C_x_bits-1:0] pixelX_q, pixelX_d;
    logic [C_y_bits-1:0] pixelY_q, pixelY_d;
    logic [15:0]   pixelColor_q, pixelColor_d;

    st7789_spi_deser u_deser (
        .clk            (clk),
        .reset          (reset),
        .oled_csn       (oled_csn),
        .oled_clk       (oled_clk),
        .oled_mosi      (oled_mosi),
        .oled_dc        (oled_dc),
        .byte_valid_o   (byteValid),
        .byte_o         (rxByte),
        .byte_is_data_o (byteIsData),
        .csn_high_o     (csnHigh)
    );

    // Command decode and data handling. A command byte always restarts the
    // decoder; data bytes are routed by the current state. On each pixel's
    // low byte the address steps along the row and wraps to the next row at
    // the window edge; out-of-panel addresses still step but raise no strobe.
    // Deselecting the chip abandons a half-received pixel.
    always_comb begin
        state_d      = state_q;
        argIdx_d     = argIdx_q;
        winRow_d     = winRow_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        phaseLow_d   = phaseLow_q;
        hi_d         = hi_q;
        pixelValid_d = 1'b0;
        pixelX_d     = pixelX_q;
        pixelY_d     = pixelY_q;
        pixelColor_d = pixelColor_q;
        if (byteValid) begin
            if (!byteIsData) begin
                if (rxByte == CMD_CASET || rxByte == CMD_RASET) begin
                    state_d  = ARGS;
                    argIdx_d = 2'd0;
                    winRow_d = (rxByte == CMD_RASET);
                end else if (rxByte == CMD_RAMWR) begin
                    state_d    = RAMWR;
                    x_d        = xs_q;
                    y_d        = ys_q;
                    phaseLow_d = 1'b0;
                end else begin
                    state_d = SKIP;
                end
            end else begin
                case (state_q)
                    ARGS: begin
                        case (argIdx_q)
                            2'd0: if (winRow_q) ys_d[15:8] = rxByte; else xs_d[15:8] = rxByte;
                            2'd1: if (winRow_q) ys_d[7:0]  = rxByte; else xs_d[7:0]  = rxByte;
                            2'd2: if (winRow_q) ye_d[15:8] = rxByte; else xe_d[15:8] = rxByte;
                            default: if (winRow_q) ye_d[7:0] = rxByte; else xe_d[7:0] = rxByte;
                        endcase
                        argIdx_d = argIdx_q + 2'd1;
                        if (argIdx_q == 2'd3) begin
                            state_d = IDLE;
                        end
                    end
                    RAMWR: begin
                        if (!phaseLow_q) begin
                            hi_d       = rxByte;
                            phaseLow_d = 1'b1;
                        end else begin
                            phaseLow_d = 1'b0;
                            if (x_q < X_SIZE16 && y_q < Y_SIZE16) begin
                                pixelValid_d = 1'b1;
                                pixelX_d     = x_q[C_x_bits-1:0];
                                pixelY_d     = y_q[C_y_bits-1:0];
                                pixelColor_d = {hi_q, rxByte};
                            end
                            if (x_q >= xe_q) begin
                                x_d = xs_q;
                                y_d = (y_q >= ye_q) ? ys_q : y_q + 16'd1;
                            end else begin
                                x_d = x_q + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (csnHigh) begin
            phaseLow_d = 1'b0;
        end
    end

    // Decoder state, window and pixel output registers. Reset restores the
    // full-panel window and clears any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            argIdx_q     <= 2'd0;
            winRow_q     <= 1'b0;
            xs_q         <= 16'd0;
            xe_q         <= X_SIZE16 - 16'd1;
            ys_q         <= 16'd0;
            ye_q         <= Y_SIZE16 - 16'd1;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            phaseLow_q   <= 1'b0;
            hi_q         <= 8'd0;
            pixelValid_q <= 1'b0;
            pixelX_q     <= '0;
            pixelY_q     <= '0;
            pixelColor_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            argIdx_q     <= argIdx_d;
            winRow_q     <= winRow_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phaseLow_q   <= phaseLow_d;
            hi_q         <= hi_d;
            pixelValid_q <= pixelValid_d;
            pixelX_q     <= pixelX_d;
            pixelY_q     <= pixelY_d;
            pixelColor_q <= pixelColor_d;
        end
    end

    assign pixel_valid = pixelValid_q;
    assign pixel_x     = pixelX_q;
    assign pixel_y     = pixelY_q;
    assign pixel_color = pixelColor_q;

`ifdef ST7789_RX_CMD_MON_EN
    logic       cmdValid_q;
    logic [7:0] cmdCode_q;

    // Command monitor: reports every command byte, decoded or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmdValid_q <= 1'b0;
            cmdCode_q  <= 8'd0;
        end else begin
            cmdValid_q <= byteValid & ~byteIsData;
            if (byteValid && !byteIsData) begin
                cmdCode_q <= rxByte;
            end
        end
    end

    assign cmd_valid = cmdValid_q;
    assign cmd_code  = cmdCode_q;
`else
    assign cmd_valid = 1'b0;
    assign cmd_code  = 8'd0;
`endif

endmodule

// File: tb/tb_st7789_spi_rx.sv
// tb_st7789_spi_rx
// Drives SPI transactions into st7789_spi_rx and compares the reported
// pixels and commands against hand-computed values.
module tb_st7789_spi_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oled_csn = 1'b1;
    logic       oled_clk = 1'b0;
    logic       oled_mosi = 1'b0;
    logic       oled_dc = 1'b0;
    logic       pixel_valid;
    logic [7:0] pixel_x;
    logic [7:0] pixel_y;
    logic [15:0] pixel_color;
    logic       cmd_valid;
    logic [7:0] cmd_code;

    int errors = 0;
    int checks = 0;

    int pixCount = 0;
    int lastX = 0;
    int lastY = 0;
    int lastColor = 0;
    int longStrobes = 0;
    logic prevValid = 1'b0;
    int cmdCount = 0;
    int lastCmd = 0;

    typedef struct {
        logic [15:0] color;
        logic        expValid;
        int          expX;
        int          expY;
    } pixVec_t;

    pixVec_t vecs[7];

    st7789_spi_rx dut (
        .clk         (clk),
        .reset       (reset),
        .oled_csn    (oled_csn),
        .oled_clk    (oled_clk),
        .oled_mosi   (oled_mosi),
        .oled_dc     (oled_dc),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code)
    );

    // 100 MHz oversampling clock.
    always #5 clk = ~clk;

    // Record every pixel and command strobe, and flag strobes longer than
    // one cycle.
    always @(negedge clk) begin
        if (pixel_valid) begin
            pixCount  <= pixCount + 1;
            lastX     <= int'(pixel_x);
            lastY     <= int'(pixel_y);
            lastColor <= int'(pixel_color);
            if (prevValid) begin
                longStrobes <= longStrobes + 1;
            end
        end
        prevValid <= pixel_valid;
        if (cmd_valid) begin
            cmdCount <= cmdCount + 1;
            lastCmd  <= int'(cmd_code);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Send the top nBits of b, MSB first, with SCK half periods of 4 clk.
    task automatic applyStimulus(input logic [7:0] b, input logic dc, input int nBits);
        logic [7:0] v;
        v = b;
        @(negedge clk);
        oled_dc = dc;
        for (int i = 7; i > 7 - nBits; i--) begin
            oled_mosi = v[i];
            repeat (4) @(negedge clk);
            oled_clk = 1'b1;
            repeat (4) @(negedge clk);
            oled_clk = 1'b0;
        end
    endtask

    task automatic sendCmd(input logic [7:0] c);
        applyStimulus(c, 1'b0, 8);
    endtask

    task automatic sendData(input logic [7:0] d);
        applyStimulus(d, 1'b1, 8);
    endtask

    // Send one RGB565 pixel and check the resulting strobe (or its absence).
    task automatic sendPixel(input string tag, input logic [15:0] color,
                             input logic expValid, input int ex, input int ey);
        int base;
        base = pixCount;
        sendData(color[15:8]);
        sendData(color[7:0]);
        repeat (8) @(negedge clk);
        if (expValid) begin
            checkOutput({tag, "_count"}, pixCount - base, 1);
            checkOutput({tag, "_x"}, lastX, ex);
            checkOutput({tag, "_y"}, lastY, ey);
            checkOutput({tag, "_color"}, lastColor, int'(color));
        end else begin
            checkOutput({tag, "_suppressed"}, pixCount - base, 0);
        end
    endtask

    initial begin
        int base;
        int cmdBase;

        vecs[0] = '{16'hF800, 1'b1, 10, 5};
        vecs[1] = '{16'h07E0, 1'b1, 11, 5};
        vecs[2] = '{16'h001F, 1'b1, 12, 5};
        vecs[3] = '{16'h1234, 1'b1, 10, 6};
        vecs[4] = '{16'h5678, 1'b1, 11, 6};
        vecs[5] = '{16'h9ABC, 1'b1, 12, 6};
        vecs[6] = '{16'hDEF0, 1'b1, 10, 5};

        repeat (4) @(negedge clk);
        checkOutput("reset_valid", int'(pixel_valid), 0);
        checkOutput("reset_x", int'(pixel_x), 0);
        checkOutput("reset_y", int'(pixel_y), 0);
        checkOutput("reset_color", int'(pixel_color), 0);
        checkOutput("reset_cmd", int'({cmd_valid, cmd_code}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        oled_csn = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] window 10..12 x 5..6, RAMWR table");
        sendCmd(8'h2A);
        sendData(8'h00); sendData(8'h0A); sendData(8'h00); sendData(8'h0C);
        sendCmd(8'h2B);
        sendData(8'h00); sendData(8'h05); sendData(8'h00); sendData(8'h06);
        sendCmd(8'h2C);
        for (int i = 0; i < 7; i++) begin
            sendPixel($sformatf("vec%0d", i), vecs[i].color, vecs[i].expValid,
                      vecs[i].expX, vecs[i].expY);
        end

        $display("[TB] unknown command 0x36 with data");
        base = pixCount;
        cmdBase = cmdCount;
        sendCmd(8'h36);
        sendData(8'h60); sendData(8'h11); sendData(8'h22);
        repeat (8) @(negedge clk);
        checkOutput("skip_no_pixel", pixCount - base, 0);
`ifdef ST7789_RX_CMD_MON_EN
        checkOutput("cmd_count", cmdCount - cmdBase, 1);
        checkOutput("cmd_code", lastCmd, 'h36);
`else
        checkOutput("cmd_tied", cmdCount, 0);
        checkOutput("cmd_code_tied", int'(cmd_code), 0);
`endif
        sendCmd(8'h2C);
        sendPixel("skip_window", 16'h0F0F, 1'b1, 10, 5);

        $display("[TB] CSN pulse drops partial byte");
        applyStimulus(8'hFF, 1'b0, 5);
        repeat (2) @(negedge clk);
        oled_csn = 1'b1;
        repeat (8) @(negedge clk);
        oled_csn = 1'b0;
        repeat (4) @(negedge clk);
        sendCmd(8'h2C);
        sendPixel("csn", 16'hAAAA, 1'b1, 10, 5);

        $display("[TB] column window 239..240 crosses panel edge");
        sendCmd(8'h2A);
        sendData(8'h00); sendData(8'hEF); sendData(8'h00); sendData(8'hF0);
        sendCmd(8'h2C);
        sendPixel("edge0", 16'h1111, 1'b1, 239, 5);
        sendPixel("edge1", 16'h2222, 1'b0, 0, 0);
        sendPixel("edge2", 16'h3333, 1'b1, 239, 6);

        $display("[TB] reset between pixel bytes");
        sendCmd(8'h2C);
        sendData(8'h55);
        reset = 1'b1;
        #1;
        checkOutput("rst_valid", int'(pixel_valid), 0);
        checkOutput("rst_x", int'(pixel_x), 0);
        checkOutput("rst_y", int'(pixel_y), 0);
        checkOutput("rst_color", int'(pixel_color), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        sendCmd(8'h2C);
        sendPixel("post_rst", 16'hBEEF, 1'b1, 0, 0);

        checkOutput("strobe_width", longStrobes, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
